rf_port_arbiter: RTL and testbench

Controller that shares the 8-entry x 4-bit register file (one write port, one combinational read port) between two requesters, A and B.
- After reset it runs an init sweep that writes INIT_VAL to every entry.
- It then grants at most one operation (read or write) per cycle, with round-robin fairness.
- It sits directly in front of the register file; the register file's ports are driven only by this block.

---
 rtl/rf_ctrl_pkg.sv | 14 +
 rtl/rr_arb2.sv | 28 ++
 rtl/rf_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_rf_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and state encoding for the register-file port controller.
package rf_ctrl_pkg;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned DATA_W   = 4;
  localparam logic [DATA_W-1:0] INIT_VAL = '0;

  typedef enum logic {
    StInit = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the requester that
// wins under contention and moves to the loser after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;  // 0: requester 0 has priority, 1: requester 1

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one register file between requesters A and B: an init sweep after
// reset, then at most one round-robin-arbitrated read or write per cycle.
module rf_port_arbiter #(
  parameter int unsigned NUM_REGS = rf_ctrl_pkg::NUM_REGS,
  parameter int unsigned ADDR_W   = rf_ctrl_pkg::ADDR_W,
  parameter int unsigned DATA_W   = rf_ctrl_pkg::DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL = rf_ctrl_pkg::INIT_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] rf_wrAddr,
  output logic [DATA_W-1:0] rf_wrVal,
  output logic              rf_wrEn,
  output logic [ADDR_W-1:0] rf_rdAddr,
  input  logic [DATA_W-1:0] rf_rdVal,
  output logic              init_done
);

  import rf_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q;
  logic              run;
  logic [1:0]        req, gnt;
  logic              a_rd_fire, b_rd_fire;
  logic              a_rvalid_q, b_rvalid_q;
  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;

  assign run = (state_q == StRun);
  // Requests are masked during the sweep so the arbiter never grants there.
  assign req = {b_req, a_req} & {2{run}};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (run),
    .gnt     (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];
  assign a_rd_fire = gnt[0] & ~a_we;
  assign b_rd_fire = gnt[1] & ~b_we;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rf_wrEn   = 1'b0;
    rf_wrAddr = '0;
    rf_wrVal  = '0;
    rf_rdAddr = '0;
    unique case (state_q)
      StInit: begin
        rf_wrEn   = 1'b1;
        rf_wrAddr = cnt_q;
        rf_wrVal  = INIT_VAL;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (gnt[0]) begin
          if (a_we) begin
            rf_wrEn   = 1'b1;
            rf_wrAddr = a_addr;
            rf_wrVal  = a_wdata;
          end else begin
            rf_rdAddr = a_addr;
          end
        end else if (gnt[1]) begin
          if (b_we) begin
            rf_wrEn   = 1'b1;
            rf_wrAddr = b_addr;
            rf_wrVal  = b_wdata;
          end else begin
            rf_rdAddr = b_addr;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == StInit) && (cnt_q == LastIdx)) begin
        init_done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      a_rvalid_q <= a_rd_fire;
      b_rvalid_q <= b_rd_fire;
      if (a_rd_fire) begin
        a_rdata_q <= rf_rdVal;
      end
      if (b_rd_fire) begin
        b_rdata_q <= rf_rdVal;
      end
    end
  end

  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Scoreboard bench for rf_port_arbiter: a behavioural model predicts grants and
// register-file traffic, read results are queued and matched by a monitor.
module tb_rf_port_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0;
  logic [2:0] a_addr = '0;
  logic [3:0] a_wdata = '0;
  logic       b_req = 1'b0, b_we = 1'b0;
  logic [2:0] b_addr = '0;
  logic [3:0] b_wdata = '0;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [3:0] a_rdata, b_rdata;
  logic [2:0] rf_wrAddr, rf_rdAddr;
  logic [3:0] rf_wrVal, rf_rdVal;
  logic       rf_wrEn, init_done;

  rf_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_gnt     (a_gnt),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_gnt     (b_gnt),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata),
    .rf_wrAddr (rf_wrAddr),
    .rf_wrVal  (rf_wrVal),
    .rf_wrEn   (rf_wrEn),
    .rf_rdAddr (rf_rdAddr),
    .rf_rdVal  (rf_rdVal),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // The register file itself, starting with garbage so the sweep matters.
  logic [3:0] mem [8];
  initial for (int i = 0; i < 8; i++) mem[i] = 4'($urandom);
  always @(posedge clk) if (rf_wrEn) mem[rf_wrAddr] <= rf_wrVal;
  assign rf_rdVal = mem[rf_rdAddr];

  typedef struct { int data; int cyc; } exp_t;
  exp_t aq[$];
  exp_t bq[$];
  int   total = 0, bad = 0, cyc = 0;
  int   ref_mem [8];
  bit   m_init = 1'b1, m_done = 1'b0, m_turn = 1'b0;
  int   m_cnt = 0;
  bit   a_fired = 1'b0, b_fired = 1'b0;
  int   last_a = 0, last_b = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic serve(input bit side, input bit we, input int addr, input int wdata);
    if (we) begin
      chk("wr_en", rf_wrEn, 1);
      chk("wr_addr", rf_wrAddr, addr);
      chk("wr_val", rf_wrVal, wdata);
      ref_mem[addr] = wdata;
    end else begin
      chk("rd_wren_low", rf_wrEn, 0);
      chk("rd_addr", rf_rdAddr, addr);
      if (side) bq.push_back('{ref_mem[addr], cyc});
      else aq.push_back('{ref_mem[addr], cyc});
    end
  endtask

  // Reference model: evaluated mid-cycle, after inputs settle.
  task automatic model_step();
    bit ga, gb;
    a_fired = 1'b0;
    b_fired = 1'b0;
    if (rst) begin
      m_init = 1'b1; m_cnt = 0; m_turn = 1'b0; m_done = 1'b0;
      aq.delete(); bq.delete();
      last_a = 0; last_b = 0;
    end else begin
      chk("init_done", init_done, m_done);
      if (m_init) begin
        chk("init_a_gnt", a_gnt, 0);
        chk("init_b_gnt", b_gnt, 0);
        chk("init_wr_en", rf_wrEn, 1);
        chk("init_wr_addr", rf_wrAddr, m_cnt);
        chk("init_wr_val", rf_wrVal, 0);
        ref_mem[m_cnt] = 0;
        if (m_cnt == 7) begin
          m_init = 1'b0;
          m_done = 1'b1;
        end else begin
          m_cnt++;
        end
      end else begin
        ga = a_req && (!b_req || !m_turn);
        gb = b_req && !ga;
        chk("a_gnt", a_gnt, int'(ga));
        chk("b_gnt", b_gnt, int'(gb));
        if (ga) serve(1'b0, a_we, int'(a_addr), int'(a_wdata));
        else if (gb) serve(1'b1, b_we, int'(b_addr), int'(b_wdata));
        else begin
          chk("idle_wr_en", rf_wrEn, 0);
          chk("idle_wr_addr", rf_wrAddr, 0);
          chk("idle_wr_val", rf_wrVal, 0);
          chk("idle_rd_addr", rf_rdAddr, 0);
        end
        if (ga) m_turn = 1'b1;
        else if (gb) m_turn = 1'b0;
        a_fired = ga;
        b_fired = gb;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #4;
    model_step();
  end

  // Monitor: matches read responses against the scoreboard queues.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (a_rvalid) begin
        if (aq.size() == 0) chk("a_rvalid_spurious", 1, 0);
        else begin
          e = aq.pop_front();
          chk("a_read_latency", cyc - e.cyc, 1);
          chk("a_rdata", a_rdata, e.data);
          last_a = e.data;
        end
      end else begin
        if (aq.size() > 0 && aq[0].cyc < cyc) begin
          chk("a_rvalid_missing", 0, 1);
          e = aq.pop_front();
        end
        chk("a_rdata_hold", a_rdata, last_a);
      end
      if (b_rvalid) begin
        if (bq.size() == 0) chk("b_rvalid_spurious", 1, 0);
        else begin
          e = bq.pop_front();
          chk("b_read_latency", cyc - e.cyc, 1);
          chk("b_rdata", b_rdata, e.data);
          last_b = e.data;
        end
      end else begin
        if (bq.size() > 0 && bq[0].cyc < cyc) begin
          chk("b_rvalid_missing", 0, 1);
          e = bq.pop_front();
        end
        chk("b_rdata_hold", b_rdata, last_b);
      end
    end
  end

  task automatic drive(input bit ar, input bit aw, input int aa, input int ad,
                       input bit br, input bit bw, input int ba, input int bd);
    @(posedge clk);
    #1;
    a_req = ar; a_we = aw; a_addr = 3'(aa); a_wdata = 4'(ad);
    b_req = br; b_we = bw; b_addr = 3'(ba); b_wdata = 4'(bd);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(9);
  endtask

  initial begin
    int waited;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waited;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Init sweep, then read entry 5
    idle(9);
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    idle(2);
    // Write then read on A
    drive(1, 1, 3, 10, 0, 0, 0, 0);
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    idle(2);
    // Contention from a fresh reset: grants alternate A, B, A, B
    do_reset();
    repeat (4) drive(1, 1, 1, 5, 1, 0, 1, 0);
    idle(2);
    // Pointer hold across idle cycles
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    idle(3);
    repeat (2) drive(1, 0, 2, 0, 1, 0, 3, 0);
    idle(2);
    // Reset in the cycle after a read grant, while another read is granted
    drive(1, 1, 3, 9, 0, 0, 0, 0);
    drive(1, 0, 3, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd3;
    #1;
    rst = 1'b1;
    #1;
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_init_done", init_done, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_req = 1'b0;
    idle(9);
    for (int i = 0; i < 8; i++) drive(1, 0, i, 0, 0, 0, 0, 0);
    idle(2);
    // Request held from reset release: granted in the first RUN cycle
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd2;
    waited = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (a_fired) begin
        waited = k;
        break;
      end
    end
    chk("init_req_wait", waited, 9);
    a_req = 1'b0;
    // Random traffic; each requester holds its operation until granted
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (!a_req || a_fired) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_we = 1'($urandom); a_addr = 3'($urandom); a_wdata = 4'($urandom);
      end
      if (!b_req || b_fired) begin
        b_req = ($urandom_range(0, 3) != 0);
        b_we = 1'($urandom); b_addr = 3'($urandom); b_wdata = 4'($urandom);
      end
    end
    idle(3);
    chk("a_queue_drained", aq.size(), 0);
    chk("b_queue_drained", bq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
